// File: rtl/picosoc_bus_arbiter.sv
// Two-master round-robin arbiter for the PicoRV32 native memory bus.
// Grant is held for a whole transaction; a watchdog aborts hung slave accesses.
module picosoc_bus_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_VALUE      = 32'hFFFF_FFFF
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_m0_valid,
    input  logic [31:0] i_m0_addr,
    input  logic [31:0] i_m0_wdata,
    input  logic [3:0]  i_m0_wstrb,
    output logic        o_m0_ready,
    output logic [31:0] o_m0_rdata,

    input  logic        i_m1_valid,
    input  logic [31:0] i_m1_addr,
    input  logic [31:0] i_m1_wdata,
    input  logic [3:0]  i_m1_wstrb,
    output logic        o_m1_ready,
    output logic [31:0] o_m1_rdata,

    output logic        o_s_valid,
    output logic [31:0] o_s_addr,
    output logic [31:0] o_s_wdata,
    output logic [3:0]  o_s_wstrb,
    input  logic        i_s_ready,
    input  logic [31:0] i_s_rdata,

    output logic [1:0]  o_grant,
    output logic        o_timeout_err,
    output logic [7:0]  o_err_count
);

    typedef enum logic {StIdle, StBusy} state_e;

    state_e      r_state, w_state_next;
    logic [1:0]  r_grant, w_grant_next;
    logic        r_last, w_last_next;     // 1 = m1 was served last
    logic [31:0] r_wdog, w_wdog_next;
    logic [7:0]  r_err_count, w_err_count_next;

    logic w_busy;
    logic w_gnt_valid;
    logic w_wdog_hit;
    logic w_done;
    logic w_timeout;
    logic w_finish;
    logic w_s_valid;

    always_comb begin
        w_busy      = (r_state == StBusy);
        w_gnt_valid = (r_grant[0] & i_m0_valid) | (r_grant[1] & i_m1_valid);
        w_wdog_hit  = (TIMEOUT_CYCLES != 0) && (r_wdog == TIMEOUT_CYCLES - 1);
        w_done      = w_busy & w_gnt_valid & i_s_ready;
        // A slave completion in the watchdog cycle wins over the timeout.
        w_timeout   = w_busy & w_gnt_valid & ~i_s_ready & w_wdog_hit;
        w_finish    = w_done | w_timeout;
        w_s_valid   = w_busy & w_gnt_valid & ~w_timeout;
    end

    always_comb begin
        w_state_next     = r_state;
        w_grant_next     = r_grant;
        w_last_next      = r_last;
        w_wdog_next      = r_wdog;
        w_err_count_next = r_err_count;

        case (r_state)
            StIdle: begin
                if (i_m0_valid || i_m1_valid) begin
                    if (i_m0_valid && i_m1_valid) begin
                        w_grant_next = r_last ? 2'b01 : 2'b10;
                    end else begin
                        w_grant_next = i_m0_valid ? 2'b01 : 2'b10;
                    end
                    w_state_next = StBusy;
                    w_wdog_next  = 32'd0;
                end
            end
            StBusy: begin
                if (!w_gnt_valid) begin
                    // Granted master withdrew its request: abandon quietly.
                    w_state_next = StIdle;
                    w_grant_next = 2'b00;
                end else if (w_finish) begin
                    w_state_next = StIdle;
                    w_grant_next = 2'b00;
                    w_last_next  = r_grant[1];
                end else begin
                    w_wdog_next = r_wdog + 32'd1;
                end
            end
            default: begin
                w_state_next = StIdle;
                w_grant_next = 2'b00;
            end
        endcase

        if (w_timeout && (r_err_count != 8'hFF)) begin
            w_err_count_next = r_err_count + 8'd1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= StIdle;
            r_grant     <= 2'b00;
            r_last      <= 1'b1;
            r_wdog      <= 32'd0;
            r_err_count <= 8'd0;
        end else begin
            r_state     <= w_state_next;
            r_grant     <= w_grant_next;
            r_last      <= w_last_next;
            r_wdog      <= w_wdog_next;
            r_err_count <= w_err_count_next;
        end
    end

    always_comb begin
        o_s_valid  = w_s_valid;
        o_s_addr   = 32'd0;
        o_s_wdata  = 32'd0;
        o_s_wstrb  = 4'd0;
        if (w_s_valid) begin
            o_s_addr  = r_grant[1] ? i_m1_addr  : i_m0_addr;
            o_s_wdata = r_grant[1] ? i_m1_wdata : i_m0_wdata;
            o_s_wstrb = r_grant[1] ? i_m1_wstrb : i_m0_wstrb;
        end

        o_m0_ready = w_finish & r_grant[0];
        o_m1_ready = w_finish & r_grant[1];
        o_m0_rdata = 32'd0;
        o_m1_rdata = 32'd0;
        if (o_m0_ready) o_m0_rdata = w_done ? i_s_rdata : ERR_VALUE;
        if (o_m1_ready) o_m1_rdata = w_done ? i_s_rdata : ERR_VALUE;

        o_grant       = r_grant;
        o_timeout_err = w_timeout;
        o_err_count   = r_err_count;
    end

endmodule

// File: tb/tb_picosoc_bus_arbiter.sv
// Self-checking bench for picosoc_bus_arbiter: directed scenarios plus a
// randomized transaction run against a transaction-level round-robin model.
module tb_picosoc_bus_arbiter;

    localparam int unsigned TO = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready;
    logic [31:0] s_rdata;
    logic [1:0]  grant;
    logic        timeout_err;
    logic [7:0]  err_count;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    picosoc_bus_arbiter #(
        .TIMEOUT_CYCLES (TO),
        .ERR_VALUE      (32'hFFFF_FFFF)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_m0_valid    (m0_valid),
        .i_m0_addr     (m0_addr),
        .i_m0_wdata    (m0_wdata),
        .i_m0_wstrb    (m0_wstrb),
        .o_m0_ready    (m0_ready),
        .o_m0_rdata    (m0_rdata),
        .i_m1_valid    (m1_valid),
        .i_m1_addr     (m1_addr),
        .i_m1_wdata    (m1_wdata),
        .i_m1_wstrb    (m1_wstrb),
        .o_m1_ready    (m1_ready),
        .o_m1_rdata    (m1_rdata),
        .o_s_valid     (s_valid),
        .o_s_addr      (s_addr),
        .o_s_wdata     (s_wdata),
        .o_s_wstrb     (s_wstrb),
        .i_s_ready     (s_ready),
        .i_s_rdata     (s_rdata),
        .o_grant       (grant),
        .o_timeout_err (timeout_err),
        .o_err_count   (err_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        m0_valid = 1'b0; m0_addr = '0; m0_wdata = '0; m0_wstrb = '0;
        m1_valid = 1'b0; m1_addr = '0; m1_wdata = '0; m1_wstrb = '0;
        s_ready  = 1'b0; s_rdata = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_inputs();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        m0_valid = 1'b1;
        s_ready  = 1'b1;
        reset    = 1'b1;
        tick();
        #1;
        n_cmp++;
        if ({grant, s_valid, m0_ready, m1_ready, timeout_err, err_count} !== 14'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got grant=%b s_valid=%b rdy=%b%b to=%b cnt=%0d want all 0",
                     grant, s_valid, m0_ready, m1_ready, timeout_err, err_count);
        end
        reset = 1'b0;
        idle_inputs();
        tick();
    endtask

    task automatic test_single_master();
        m0_valid = 1'b1; m0_addr = 32'h0000_0010; m0_wstrb = 4'b0000;
        #1;
        n_cmp++;
        if (s_valid !== 1'b0) begin
            n_err++; $display("FAIL single_idle_svalid: got %b want 0", s_valid);
        end
        tick(); #1;
        n_cmp++;
        if ({grant, s_valid} !== 3'b011 || s_addr !== 32'h0000_0010) begin
            n_err++;
            $display("FAIL single_cycle1: got grant=%b s_valid=%b addr=%h want 01/1/00000010",
                     grant, s_valid, s_addr);
        end
        tick(); #1;
        n_cmp++;
        if ({m0_ready, m1_ready, m0_rdata} !== 34'd0) begin
            n_err++; $display("FAIL single_cycle2: got rdy=%b%b rdata=%h want 0", m0_ready, m1_ready, m0_rdata);
        end
        tick();
        s_ready = 1'b1; s_rdata = 32'h1234_5678;
        #1;
        n_cmp++;
        if ({m0_ready, m1_ready} !== 2'b10 || m0_rdata !== 32'h1234_5678) begin
            n_err++;
            $display("FAIL single_done: got rdy=%b%b rdata=%h want 10/12345678", m0_ready, m1_ready, m0_rdata);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if ({grant, m0_ready, m0_rdata} !== 35'd0) begin
            n_err++; $display("FAIL single_after: got grant=%b rdy=%b rdata=%h want 0", grant, m0_ready, m0_rdata);
        end
    endtask

    task automatic test_tie();
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_1000;
        m1_valid = 1'b1; m1_addr = 32'h0000_2000;
        tick();
        s_ready = 1'b1;
        #1;
        n_cmp++;
        if (grant !== 2'b01 || s_addr !== 32'h0000_1000 || {m0_ready, m1_ready} !== 2'b10) begin
            n_err++;
            $display("FAIL tie_first: got grant=%b addr=%h rdy=%b%b want 01/00001000/10",
                     grant, s_addr, m0_ready, m1_ready);
        end
        tick();
        m0_valid = 1'b0; s_ready = 1'b0;
        #1;
        n_cmp++;
        if ({grant, s_valid} !== 3'b000) begin
            n_err++; $display("FAIL tie_gap: got grant=%b s_valid=%b want 00/0", grant, s_valid);
        end
        tick();
        s_ready = 1'b1;
        #1;
        n_cmp++;
        if (grant !== 2'b10 || s_addr !== 32'h0000_2000 || {m0_ready, m1_ready} !== 2'b01) begin
            n_err++;
            $display("FAIL tie_second: got grant=%b addr=%h rdy=%b%b want 10/00002000/01",
                     grant, s_addr, m0_ready, m1_ready);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_write_mux();
        m1_valid = 1'b1; m1_addr = 32'h0200_0004; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011;
        m0_addr = 32'h5555_5555; m0_wdata = 32'h6666_6666; m0_wstrb = 4'b1111;
        #1;
        n_cmp++;
        if ({s_addr, s_wdata, s_wstrb} !== 68'd0) begin
            n_err++; $display("FAIL wmux_idle_zero: got addr=%h data=%h strb=%b want 0", s_addr, s_wdata, s_wstrb);
        end
        tick(); #1;
        n_cmp++;
        if (grant !== 2'b10 || s_addr !== 32'h0200_0004 || s_wdata !== 32'hAABB_CCDD
            || s_wstrb !== 4'b0011) begin
            n_err++;
            $display("FAIL wmux_fields: got grant=%b addr=%h data=%h strb=%b want 10/02000004/aabbccdd/0011",
                     grant, s_addr, s_wdata, s_wstrb);
        end
        s_ready = 1'b1;
        #1;
        n_cmp++;
        if ({m0_ready, m1_ready} !== 2'b01) begin
            n_err++; $display("FAIL wmux_ready: got rdy=%b%b want 01", m0_ready, m1_ready);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_timeout();
        m0_valid = 1'b1; m0_addr = 32'h0000_0040;
        for (int c = 1; c <= int'(TO); c++) begin
            tick(); #1;
            n_cmp++;
            if (c < int'(TO)) begin
                if ({s_valid, m0_ready, timeout_err} !== 3'b100) begin
                    n_err++;
                    $display("FAIL timeout_wait c%0d: got sv/rdy/to=%b%b%b want 100", c, s_valid, m0_ready, timeout_err);
                end
            end else begin
                if ({s_valid, m0_ready, m1_ready, timeout_err} !== 4'b0101
                    || m0_rdata !== 32'hFFFF_FFFF || err_count !== 8'd0) begin
                    n_err++;
                    $display("FAIL timeout_fire: got sv/r0/r1/to=%b%b%b%b rdata=%h cnt=%0d want 0101/ffffffff/0",
                             s_valid, m0_ready, m1_ready, timeout_err, m0_rdata, err_count);
                end
            end
        end
        tick();
        m0_valid = 1'b0;
        #1;
        n_cmp++;
        if (err_count !== 8'd1 || timeout_err !== 1'b0) begin
            n_err++; $display("FAIL timeout_count: got cnt=%0d to=%b want 1/0", err_count, timeout_err);
        end
        m0_valid = 1'b1;
        for (int c = 1; c <= int'(TO); c++) begin
            tick();
            s_ready = (c == int'(TO));
            s_rdata = 32'hCAFE_0008;
            #1;
        end
        n_cmp++;
        if (m0_ready !== 1'b1 || m0_rdata !== 32'hCAFE_0008 || timeout_err !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_race: got rdy=%b rdata=%h to=%b want 1/cafe0008/0", m0_ready, m0_rdata, timeout_err);
        end
        tick();
        idle_inputs();
        #1;
        n_cmp++;
        if (err_count !== 8'd1) begin
            n_err++; $display("FAIL timeout_race_count: got %0d want 1", err_count);
        end
    endtask

    // Transaction-level model: round-robin winner from the last-served pointer,
    // completion at the slave latency or at the watchdog limit, whichever comes first.
    task automatic test_random();
        int model_last;
        int model_err;
        logic [31:0] a [2];
        logic [31:0] d [2];
        logic [3:0]  w [2];
        do_reset();
        model_last = 1;
        model_err  = 0;
        for (int it = 0; it < 40; it++) begin
            int req, lat, win, end_c;
            logic is_to;
            logic [1:0] exp_gnt;
            logic [31:0] rd;
            req = int'($urandom_range(1, 3));
            lat = int'($urandom_range(1, 10));
            for (int m = 0; m < 2; m++) begin
                a[m] = $urandom; d[m] = $urandom; w[m] = 4'($urandom);
            end
            m0_valid = req[0]; m0_addr = a[0]; m0_wdata = d[0]; m0_wstrb = w[0];
            m1_valid = req[1]; m1_addr = a[1]; m1_wdata = d[1]; m1_wstrb = w[1];
            s_ready = 1'b0;
            #1;
            n_cmp++;
            if ({grant, s_valid} !== 3'b000 || err_count !== 8'(model_err)) begin
                n_err++;
                $display("FAIL rand_idle it%0d: got grant=%b sv=%b cnt=%0d want 00/0/%0d",
                         it, grant, s_valid, err_count, model_err);
            end
            win     = (req == 3) ? (model_last == 1 ? 0 : 1) : (req == 2 ? 1 : 0);
            exp_gnt = (win == 1) ? 2'b10 : 2'b01;
            is_to   = (lat > int'(TO));
            end_c   = is_to ? int'(TO) : lat;
            for (int c = 1; c <= end_c; c++) begin
                logic [3:0] exp_flags;
                tick();
                s_ready = (c == lat);
                rd = $urandom;
                s_rdata = rd;
                #1;
                if (c < end_c)   exp_flags = 4'b0001;
                else if (is_to)  exp_flags = {exp_gnt[0], exp_gnt[1], 2'b10};
                else             exp_flags = {exp_gnt[0], exp_gnt[1], 2'b01};
                n_cmp++;
                if (grant !== exp_gnt || {m0_ready, m1_ready, timeout_err, s_valid} !== exp_flags) begin
                    n_err++;
                    $display("FAIL rand_flags it%0d c%0d: got grant=%b r0r1/to/sv=%b%b%b%b want %b/%b",
                             it, c, grant, m0_ready, m1_ready, timeout_err, s_valid, exp_gnt, exp_flags);
                end
                if (exp_flags[0]) begin
                    n_cmp++;
                    if (s_addr !== a[win] || s_wdata !== d[win] || s_wstrb !== w[win]) begin
                        n_err++;
                        $display("FAIL rand_mux it%0d c%0d: got %h/%h/%b want %h/%h/%b",
                                 it, c, s_addr, s_wdata, s_wstrb, a[win], d[win], w[win]);
                    end
                end
                if (c == end_c) begin
                    logic [31:0] got;
                    got = (win == 1) ? m1_rdata : m0_rdata;
                    n_cmp++;
                    if (got !== (is_to ? 32'hFFFF_FFFF : rd)) begin
                        n_err++;
                        $display("FAIL rand_rdata it%0d: got %h want %h", it, got, is_to ? 32'hFFFF_FFFF : rd);
                    end
                end
            end
            model_last = win;
            if (is_to && model_err < 255) model_err++;
            tick();
            idle_inputs();
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        m0_valid = 1'b1; m0_addr = 32'h0000_0100;
        m1_valid = 1'b1; m1_addr = 32'h0000_0200;
        s_ready  = 1'b1;
        for (int c = 1; c <= 16; c++) begin
            logic [1:0] exp_gnt;
            tick(); #1;
            if (c % 2 == 0)                  exp_gnt = 2'b00;
            else if (((c - 1) / 2) % 2 == 0) exp_gnt = 2'b01;
            else                             exp_gnt = 2'b10;
            n_cmp++;
            if (grant !== exp_gnt || {m1_ready, m0_ready} !== exp_gnt) begin
                n_err++;
                $display("FAIL b2b c%0d: got grant=%b rdy(m1m0)=%b%b want %b", c, grant, m1_ready, m0_ready, exp_gnt);
            end
        end
        idle_inputs();
        tick();
    endtask

    task automatic test_valid_drop();
        do_reset();
        m1_valid = 1'b1; m1_addr = 32'h0000_0300;
        tick(); #1;
        n_cmp++;
        if (grant !== 2'b10) begin
            n_err++; $display("FAIL drop_grant: got %b want 10", grant);
        end
        tick();
        m0_valid = 1'b1; m0_addr = 32'h0000_0400;
        tick();
        m1_valid = 1'b0; s_ready = 1'b1;
        #1;
        n_cmp++;
        if ({s_valid, m0_ready, m1_ready, timeout_err} !== 4'b0000) begin
            n_err++;
            $display("FAIL drop_same_cycle: got sv/r0/r1/to=%b%b%b%b want 0000", s_valid, m0_ready, m1_ready, timeout_err);
        end
        tick();
        s_ready = 1'b0;
        #1;
        n_cmp++;
        if ({grant, s_valid} !== 3'b000) begin
            n_err++; $display("FAIL drop_idle: got grant=%b sv=%b want 00/0", grant, s_valid);
        end
        tick();
        s_ready = 1'b1;
        #1;
        n_cmp++;
        if (grant !== 2'b01 || s_addr !== 32'h0000_0400 || m0_ready !== 1'b1) begin
            n_err++; $display("FAIL drop_next_m0: got grant=%b addr=%h rdy=%b want 01/00000400/1", grant, s_addr, m0_ready);
        end
        tick();
        idle_inputs();
        tick();
    endtask

    task automatic test_saturation();
        int pulses;
        pulses = 0;
        m0_valid = 1'b1; m0_addr = 32'h0000_0500;
        for (int i = 0; i < 300 * (int'(TO) + 1); i++) begin
            tick(); #1;
            if (timeout_err === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 300) begin
            n_err++; $display("FAIL sat_pulses: got %0d want 300", pulses);
        end
        n_cmp++;
        if (err_count !== 8'd255) begin
            n_err++; $display("FAIL sat_count: got %0d want 255", err_count);
        end
    endtask

    task automatic test_reset_mid();
        m0_valid = 1'b1; m1_valid = 1'b0; s_ready = 1'b0;
        tick(); #1;
        n_cmp++;
        if (grant !== 2'b01 || s_valid !== 1'b1) begin
            n_err++; $display("FAIL rstmid_busy: got grant=%b sv=%b want 01/1", grant, s_valid);
        end
        reset = 1'b1;
        tick(); #1;
        n_cmp++;
        if ({grant, s_valid, m0_ready, m1_ready, timeout_err, err_count} !== 14'd0) begin
            n_err++;
            $display("FAIL rstmid_zero: got grant=%b sv=%b rdy=%b%b to=%b cnt=%0d want all 0",
                     grant, s_valid, m0_ready, m1_ready, timeout_err, err_count);
        end
        reset = 1'b0;
        m1_valid = 1'b1;
        tick();
        s_ready = 1'b1;
        #1;
        n_cmp++;
        if (grant !== 2'b01 || {m0_ready, m1_ready} !== 2'b10) begin
            n_err++; $display("FAIL rstmid_tie: got grant=%b rdy=%b%b want 01/10", grant, m0_ready, m1_ready);
        end
        tick();
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_master();
        test_tie();
        test_write_mux();
        test_timeout();
        test_random();
        test_back_to_back();
        test_valid_drop();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL sim_time_limit: got still running want finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/picosoc_bus_arbiter.md
# picosoc_bus_arbiter

- Two-master, one-slave round-robin arbiter on the PicoRV32 native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Sits between the CPU (master 0) and a second bus master such as a DMA engine or debug port (master 1), and the SoC memory/peripheral decode.
- Holds the grant for the whole transaction and enforces a per-transaction watchdog that terminates hung slave accesses with an error response.

## Interface
Parameters:
- TIMEOUT_CYCLES, default 255: cycles in BUSY without `s_ready` before forced termination. 0 disables the watchdog.
- ERR_VALUE, default 32'hFFFF_FFFF: read data returned on a timed-out access.

Ports:
- clk  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  synchronous, active-high reset.
- m0_valid / m1_valid  in  1  master request; held until that master's ready.
- m0_addr / m1_addr  in  32  request address.
- m0_wdata / m1_wdata  in  32  write data.
- m0_wstrb / m1_wstrb  in  4  byte write strobes; 0 = read.
- m0_ready / m1_ready  out  1  transaction complete, single-cycle pulse.
- m0_rdata / m1_rdata  out  32  read data, valid with ready; otherwise 0.
- s_valid  out  1  request to slave.
- s_addr, s_wdata, s_wstrb  out  32/32/4  muxed from granted master; 0 when `s_valid`=0.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data.
- grant  out  2  one-hot registered grant (bit0 = m0); 0 in IDLE.
- timeout_err  out  1  one-cycle pulse on watchdog termination.
- err_count  out  8  saturating count of timeouts.

## Operation
- State machine: IDLE, BUSY.
- IDLE:
  - If exactly one `mX_valid` is high, register grant to it.
  - If both are high, grant the master not served last (`last` pointer).
  - Enter BUSY and clear the watchdog counter.
  - `s_valid`=0 in IDLE.
- BUSY:
  - `s_valid` = granted master's valid; slave address, data and strobes are combinationally muxed from the granted master.
  - On `s_ready`=1 with `s_valid`=1: pulse granted `mX_ready`, route `s_rdata` to its rdata, set `last` = granted, return to IDLE.
  - The ungranted master never sees ready.
- Watchdog:
  - Counter increments each BUSY cycle without `s_ready`.
  - When counter == TIMEOUT_CYCLES-1 and `s_ready`=0: that cycle drives `s_valid`=0, pulses granted `mX_ready` with rdata = ERR_VALUE, pulses `timeout_err`, increments `err_count` (saturates at 255), sets `last`, returns to IDLE.
  - Writes time out identically; rdata value is don't-care for the master.
- `s_ready` and timeout in the same cycle: `s_ready` wins; normal completion, no error.
- Granted master drops valid in BUSY (protocol violation): `s_valid` falls, return to IDLE next cycle, no ready, `last` unchanged.
- `s_ready` while `s_valid`=0 is ignored.
- Reset: state IDLE, grant 0, `last` = 1 (m0 wins the first tie), counter 0, `err_count` 0. All outputs read 0 the cycle after reset is sampled high, including mid-transaction (that transaction is abandoned).

## Timing
- Arbitration latency: `s_valid` asserts the cycle after a master's valid is first seen in IDLE.
- Completion: `mX_ready` is combinational from `s_ready` in the same cycle; slave rdata passes through with zero added latency.
- One idle cycle between transactions (ready cycle → IDLE → next grant). Minimum per-access cost = slave latency + 2 cycles.
- Back-to-back contention strictly alternates m0, m1, m0, …
- Timeout fires on cycle TIMEOUT_CYCLES of BUSY (cycle 1 = first BUSY cycle).

## Test plan
- **Single master:** m0 read, addr 0x0000_0010, slave `s_ready` after 3 cycles with rdata 0x1234_5678 → `s_valid` from cycle 1, `m0_ready` pulse with 0x1234_5678, `grant` = 01 then 00, `m1_ready` never high.
- **Tie after reset:** m0 and m1 request simultaneously → m0 served first, then m1 after one idle cycle. Four continuous requests from each master → order m0, m1, m0, m1, …
- **Write mux:** m1 writes wstrb 4'b0011, wdata 0xAABB_CCDD to 0x0200_0004 → `s_wstrb` = 0011, `s_addr` = 0x0200_0004, `s_wdata` = 0xAABB_CCDD while `grant` = 10.
- **Timeout:** TIMEOUT_CYCLES = 8, slave never ready → on the 8th BUSY cycle `m0_ready` = 1 with rdata 0xFFFF_FFFF, `timeout_err` pulse, `err_count` = 1. With `s_ready` on the 8th cycle instead → normal completion, `err_count` unchanged. With 300 timeouts → `err_count` = 255.
- **Reset mid-transaction:** reset asserted in BUSY → next cycle `s_valid`, `grant`, readies and `err_count` are 0. A subsequent tie goes to m0.
- **Valid drop:** granted m1 deasserts valid in BUSY → `s_valid` falls the same cycle, no `m1_ready`, and a pending m0 is granted next.
